// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : fetch_pkg                                                 |
// | Description : Shared types and constants for the instruction fetch unit: |
// |               FSM state encoding, fault codes and the sequential PC step.|
// | Ports       : none (package)                                            |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_HANDOFF = 3'd2,
    ST_EXEC    = 3'd3,
    ST_FAULT   = 3'd4
  } fetch_state_t;

  typedef logic [1:0] fault_code_t;

  localparam fault_code_t FAULT_NONE     = 2'd0;
  localparam fault_code_t FAULT_BUS      = 2'd1;
  localparam fault_code_t FAULT_TIMEOUT  = 2'd2;
  localparam fault_code_t FAULT_MISALIGN = 2'd3;

  localparam int unsigned PC_STEP        = 4;
  // Wide enough for the largest supported MAX_WAIT (255).
  localparam int unsigned WAIT_CNT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// | Module      : instruction_fetch_unit_if                                 |
// | Description : Instruction memory req/ack bus.                           |
// |   req   : fetch request, held until ack (master -> slave)               |
// |   addr  : fetch address, stable while req (master -> slave)             |
// |   ack   : rdata/err valid this cycle (slave -> master)                  |
// |   rdata : fetched instruction word (slave -> master)                    |
// |   err   : bus error, qualified by ack (slave -> master)                 |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic                   req;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   ack;
  logic [INSTR_WIDTH-1:0] rdata;
  logic                   err;

  modport master (output req, addr, input ack, rdata, err);
  modport slave  (input req, addr, output ack, rdata, err);

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit_watchdog.sv
// ---------------------------------------------------------------------------
// | Module      : fetch_watchdog                                            |
// | Description : Counts consecutive unacknowledged fetch cycles.           |
// |   clk      in  : clock                                                  |
// |   reset    in  : synchronous active-low reset                           |
// |   clear    in  : forces the count to zero                               |
// |   count_en in  : one more cycle without ack                             |
// |   expired  out : the current cycle is the MAX_WAIT-th without ack       |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WAIT_CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The count holds the number of earlier no-ack cycles, so reaching
  // MAX_WAIT-1 means this cycle is the last one allowed.
  assign expired = (r_count == WAIT_CNT_WIDTH'(MAX_WAIT - 1));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// | Module      : instruction_fetch_unit                                    |
// | Description : Front end of the 4-phase core. Fetches one instruction    |
// |               per pipeline pass, hands it to the pipeline controller    |
// |               and advances the PC on writeback (sequential or branch).  |
// |   clk            in  : clock                                            |
// |   reset          in  : synchronous active-low reset                     |
// |   enable         in  : fetch the next instruction when idle             |
// |   imem           if  : instruction memory bus (master)                  |
// |   start          out : instruction ready for the pipeline controller    |
// |   active         in  : pipeline controller busy                         |
// |   writebackState in  : pipeline in writeback phase                      |
// |   branch_taken   in  : take branch_target on writeback                  |
// |   branch_target  in  : next PC when branch_taken                        |
// |   instruction    out : current instruction                              |
// |   instr_pc       out : PC of current instruction                        |
// |   fault          out : sticky fault flag                                |
// |   fault_code     out : 0 none, 1 bus error, 2 timeout, 3 misaligned     |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          MAX_WAIT    = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  instruction_fetch_unit_if.master imem,
  output logic                     start,
  input  logic                     active,
  input  logic                     writebackState,
  input  logic                     branch_taken,
  input  logic [ADDR_WIDTH-1:0]    branch_target,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic [ADDR_WIDTH-1:0]    instr_pc,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  fetch_state_t           r_state;
  fetch_state_t           w_stateNext;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [INSTR_WIDTH-1:0] r_instruction;
  logic [ADDR_WIDTH-1:0]  r_instrPc;
  logic                   r_fault;
  fault_code_t            r_faultCode;

  logic                   w_latch;
  logic                   w_advance;
  logic                   w_faultSet;
  fault_code_t            w_faultCode;
  logic                   w_wdExpired;

  // Counter is held at zero outside FETCH, so every fetch starts fresh.
  fetch_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state != ST_FETCH),
    .count_en ((r_state == ST_FETCH) && !imem.ack),
    .expired  (w_wdExpired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_latch     = 1'b0;
    w_advance   = 1'b0;
    w_faultSet  = 1'b0;
    w_faultCode = FAULT_NONE;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_stateNext = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // An ack on the final allowed cycle wins over the timeout.
        if (imem.ack) begin
          if (imem.err) begin
            w_stateNext = ST_FAULT;
            w_faultSet  = 1'b1;
            w_faultCode = FAULT_BUS;
          end else begin
            w_stateNext = ST_HANDOFF;
            w_latch     = 1'b1;
          end
        end else if (w_wdExpired) begin
          w_stateNext = ST_FAULT;
          w_faultSet  = 1'b1;
          w_faultCode = FAULT_TIMEOUT;
        end
      end
      ST_HANDOFF: begin
        if (active) begin
          w_stateNext = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (active && writebackState) begin
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            w_stateNext = ST_FAULT;
            w_faultSet  = 1'b1;
            w_faultCode = FAULT_MISALIGN;
          end else begin
            w_advance   = 1'b1;
            w_stateNext = enable ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_FAULT: begin
        w_stateNext = ST_FAULT;
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_instrPc     <= RESET_PC;
      r_fault       <= 1'b0;
      r_faultCode   <= FAULT_NONE;
    end else begin
      if (w_latch) begin
        r_instruction <= imem.rdata;
        r_instrPc     <= r_pc;
      end
      // Sequential step wraps silently at the top of the address space.
      if (w_advance) begin
        r_pc <= branch_taken ? branch_target : (r_pc + ADDR_WIDTH'(PC_STEP));
      end
      if (w_faultSet) begin
        r_fault     <= 1'b1;
        r_faultCode <= w_faultCode;
      end
    end
  end

  assign imem.req    = (r_state == ST_FETCH);
  assign imem.addr   = r_pc;
  assign start       = (r_state == ST_HANDOFF);
  assign instruction = r_instruction;
  assign instr_pc    = r_instrPc;
  assign fault       = r_fault;
  assign fault_code  = r_faultCode;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// | Module      : tb_instruction_fetch_unit                                 |
// | Description : Directed self-checking bench for instruction_fetch_unit.  |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic        active;
  logic        writebackState;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        fault;
  logic [1:0]  fault_code;

  int checks = 0;
  int fails  = 0;

  instruction_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  instruction_fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (32'h0),
    .MAX_WAIT    (15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .imem           (imem),
    .start          (start),
    .active         (active),
    .writebackState (writebackState),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset          = 1'b0;
    enable         = 1'b0;
    active         = 1'b0;
    writebackState = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
    imem.ack       = 1'b0;
    imem.err       = 1'b0;
    imem.rdata     = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic ack_with(input logic [31:0] data, input logic e);
    imem.ack   = 1'b1;
    imem.rdata = data;
    imem.err   = e;
    tick();
    imem.ack   = 1'b0;
    imem.err   = 1'b0;
  endtask

  task automatic writeback(input logic bt, input logic [31:0] tgt);
    active         = 1'b1;
    writebackState = 1'b1;
    branch_taken   = bt;
    branch_target  = tgt;
    tick();
    writebackState = 1'b0;
    branch_taken   = 1'b0;
    active         = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({imem.req, start, fault, fault_code} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: req/start/fault/code got %b expected 00000",
               {imem.req, start, fault, fault_code});
    end
    checks++;
    if ({instruction, instr_pc, imem.addr} !== 96'h0) begin
      fails++;
      $display("FAIL reset_regs: instr=%h instr_pc=%h addr=%h expected all 0",
               instruction, instr_pc, imem.addr);
    end
    tick();
    checks++;
    if (imem.req !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_req: req got %b expected 0", imem.req);
    end
  endtask

  task automatic test_fetch;
    enable = 1'b1;
    tick();
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
      fails++;
      $display("FAIL fetch_req: req=%b addr=%h expected 1 / 00000000", imem.req, imem.addr);
    end
    tick();
    checks++;
    if (imem.req !== 1'b1 || start !== 1'b0) begin
      fails++;
      $display("FAIL fetch_wait: req=%b start=%b expected 1 / 0", imem.req, start);
    end
    ack_with(32'h0050_0093, 1'b0);
    checks++;
    if (start !== 1'b1 || instruction !== 32'h0050_0093 || instr_pc !== 32'h0 || imem.req !== 1'b0) begin
      fails++;
      $display("FAIL handoff: start=%b instr=%h pc=%h req=%b expected 1 00500093 00000000 0",
               start, instruction, instr_pc, imem.req);
    end
    // Ack with error while not fetching must be ignored.
    ack_with(32'hFFFF_FFFF, 1'b1);
    checks++;
    if (start !== 1'b1 || fault !== 1'b0 || instruction !== 32'h0050_0093) begin
      fails++;
      $display("FAIL ack_ignored: start=%b fault=%b instr=%h expected 1 0 00500093",
               start, fault, instruction);
    end
    active = 1'b1;
    tick();
    checks++;
    if (start !== 1'b0 || imem.req !== 1'b0) begin
      fails++;
      $display("FAIL start_drop: start=%b req=%b expected 0 / 0", start, imem.req);
    end
  endtask

  task automatic test_sequential;
    writeback(1'b0, 32'h0);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin
      fails++;
      $display("FAIL seq_step: req=%b addr=%h expected 1 / 00000004", imem.req, imem.addr);
    end
  endtask

  task automatic test_branch;
    ack_with(32'h00A0_0113, 1'b0);
    checks++;
    if (instr_pc !== 32'h4 || instruction !== 32'h00A0_0113) begin
      fails++;
      $display("FAIL second_latch: pc=%h instr=%h expected 00000004 00a00113", instr_pc, instruction);
    end
    active = 1'b1;
    tick();
    writeback(1'b1, 32'h100);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h100) begin
      fails++;
      $display("FAIL branch_target: req=%b addr=%h expected 1 / 00000100", imem.req, imem.addr);
    end
    ack_with(32'h0000_0013, 1'b0);
    active = 1'b1;
    tick();
    writeback(1'b1, 32'h102);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd3 || imem.req !== 1'b0 || imem.addr !== 32'h100) begin
      fails++;
      $display("FAIL misalign: fault=%b code=%0d req=%b addr=%h expected 1 3 0 00000100",
               fault, fault_code, imem.req, imem.addr);
    end
    enable = 1'b1;
    tick();
    tick();
    checks++;
    if (imem.req !== 1'b0 || start !== 1'b0 || fault !== 1'b1 || instr_pc !== 32'h100) begin
      fails++;
      $display("FAIL fault_sticky: req=%b start=%b fault=%b pc=%h expected 0 0 1 00000100",
               imem.req, start, fault, instr_pc);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (imem.req !== 1'b1 || fault !== 1'b0) begin
      fails++;
      $display("FAIL wait_15th: req=%b fault=%b expected 1 / 0", imem.req, fault);
    end
    tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || imem.req !== 1'b0) begin
      fails++;
      $display("FAIL timeout: fault=%b code=%0d req=%b expected 1 2 0", fault, fault_code, imem.req);
    end
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) tick();
    ack_with(32'h0, 1'b1);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || imem.req !== 1'b0) begin
      fails++;
      $display("FAIL err_precedence: fault=%b code=%0d req=%b expected 1 1 0", fault, fault_code, imem.req);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    enable = 1'b1;
    tick();
    ack_with(32'h1, 1'b0);
    active = 1'b1;
    tick();
    writeback(1'b1, 32'hFFFF_FFFC);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL top_addr: req=%b addr=%h expected 1 / fffffffc", imem.req, imem.addr);
    end
    ack_with(32'h2, 1'b0);
    active = 1'b1;
    tick();
    writeback(1'b0, 32'h0);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h0 || fault !== 1'b0) begin
      fails++;
      $display("FAIL pc_wrap: req=%b addr=%h fault=%b expected 1 00000000 0", imem.req, imem.addr, fault);
    end
  endtask

  task automatic test_reset_mid;
    ack_with(32'h3, 1'b0);
    active = 1'b1;
    tick();
    writeback(1'b1, 32'h40);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== 32'h40) begin
      fails++;
      $display("FAIL pre_reset_fetch: req=%b addr=%h expected 1 / 00000040", imem.req, imem.addr);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (imem.req !== 1'b0 || start !== 1'b0 || imem.addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_fetch: req=%b start=%b addr=%h expected 0 0 00000000",
               imem.req, start, imem.addr);
    end
    tick();
    ack_with(32'hDEAD_BEEF, 1'b0);
    active = 1'b1;
    tick();
    writeback(1'b0, 32'h0);
    ack_with(32'h1234_5678, 1'b0);
    active = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    enable = 1'b0;
    active = 1'b0;
    checks++;
    if (imem.req !== 1'b0 || start !== 1'b0 || imem.addr !== 32'h0 ||
        instruction !== 32'h0 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_exec: req=%b start=%b addr=%h instr=%h pc=%h expected 0 0 0 0 0",
               imem.req, start, imem.addr, instruction, instr_pc);
    end
    enable = 1'b1;
    tick();
    ack_with(32'hCAFE_0013, 1'b0);
    active = 1'b1;
    tick();
    enable = 1'b0;
    writeback(1'b0, 32'h0);
    checks++;
    if (imem.req !== 1'b0 || imem.addr !== 32'h4 || instruction !== 32'hCAFE_0013) begin
      fails++;
      $display("FAIL disable_exec: req=%b addr=%h instr=%h expected 0 00000004 cafe0013",
               imem.req, imem.addr, instruction);
    end
    tick();
    tick();
    tick();
    checks++;
    if (imem.req !== 1'b0 || start !== 1'b0) begin
      fails++;
      $display("FAIL stays_idle: req=%b start=%b expected 0 / 0", imem.req, start);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sequential();
    test_branch();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
